row_collect_fifo: RTL
=====================

ROW_COLLECT_FIFO -- requirements
Module: row_collect_fifo

Interface
REQ-001 Parameter DIM, default 8, number of elements per row.
REQ-002 Parameter BITS, default 8, width of each element.
REQ-003 Reset and clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  Cin valid this cycle; the element is accepted only when en && ready.
REQ-007 Cin  input  BITS  serial element input, one element per accepted cycle.
REQ-008 ready  output  1  collector can accept an element this cycle.
REQ-009 rd  input  1  consumer takes Cout this cycle; ignored when Cvalid=0.
REQ-010 Cout  output  BITS x [DIM-1:0] (unpacked)  assembled row; matrix element 0 sits at Cout[DIM-1].
REQ-011 Cvalid  output  1  Cout holds an unconsumed complete row.
REQ-012 count  output  $clog2(DIM+1)  number of elements currently held in the collector.

Function
REQ-013 The block is the serial-to-parallel counterpart of the parallel-load/serial-shift transpose buffer: it assembles DIM serial elements into one row.
REQ-014 Storage consists of a collector (DIM entries plus count) and a single hold register (Cout/Cvalid), which gives double buffering.
REQ-015 accept = en && ready; the k-th accepted element of a row (k = 0..DIM-1) is written to collector entry DIM-1-k.
REQ-016 Collector states: FILL (count < DIM) and STALL (count == DIM); ready = (state == FILL).
REQ-017 Transfer condition: xfer_ok = !Cvalid || rd.
REQ-018 FILL, accept with count < DIM-1: count increments by 1.
REQ-019 FILL, accept with count == DIM-1 and xfer_ok: the completed row, including the current Cin, loads into Cout next cycle; Cvalid <= 1; count <= 0; state stays FILL.
REQ-020 FILL, accept with count == DIM-1 and !xfer_ok: count <= DIM and state moves to STALL.
REQ-021 STALL with xfer_ok: collector contents load into Cout; Cvalid <= 1; count <= 0; state moves to FILL.
REQ-022 STALL with !xfer_ok: all state holds; ready = 0, and en is ignored.
REQ-023 rd && Cvalid with no transfer in the same cycle: Cvalid <= 0; Cout retains its stale value.
REQ-024 rd and a transfer in the same cycle: the new row replaces the old row with no bubble, and Cvalid stays 1.
REQ-025 Latency: Cvalid rises one cycle after the accepting edge of the last element when xfer_ok holds.
REQ-026 Sustained throughput: one element per cycle when the consumer asserts rd in the cycle Cvalid first rises.
REQ-027 Collector entries that are not yet written in the current row are don't-care and never appear on Cout.
REQ-028 en asserted while ready = 0 drops no data and corrupts no state; the producer holds Cin until accepted.

Reset
REQ-029 Asserting rst immediately sets count = 0, state = FILL, Cvalid = 0, Cout = all zeros and collector entries = zeros, so ready = 1.
REQ-030 Reset asserted mid-row discards the partial row and any held row; the first accepted element after deassertion is element 0 of a new row.

Structure
REQ-031 A shared package systolic_pkg holds the default DIM/BITS constants and the state enum typedef {FILL, STALL}.
REQ-032 The block is a single module with no sub-modules; the collector and hold register are inline always_ff blocks.

Verification
REQ-033 Reset then 8 consecutive accepts of Cin = 1..8 with rd = 0 -> Cvalid = 1 one cycle after the 8th accept; Cout[7] = 1 through Cout[0] = 8; count = 0; ready = 1.
REQ-034 With a row held and rd = 0, feed 8 more elements 9..16 -> count = 8, ready = 0, Cout unchanged; pulse rd -> Cout[7] = 9 through Cout[0] = 16 next cycle, Cvalid = 1, ready = 1.
REQ-035 Continuous en with 24 elements, rd asserted every cycle Cvalid = 1 -> three rows appear on back-to-back 8-cycle boundaries; ready never drops; no element lost.
REQ-036 Accept 5 elements, assert rst for 1 cycle, then accept 8 elements 20..27 -> Cout[7] = 20 through Cout[0] = 27; none of the first 5 values appear.
REQ-037 In STALL, hold en = 1 with varying Cin for 4 cycles, then assert rd -> the transferred row equals the pre-stall data and count = 0.
REQ-038 Single row consumed with rd, no new data -> Cvalid = 0 the next cycle, ready stays 1, count stays 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and state typedef for the systolic array helper blocks.
package systolic_pkg;

    localparam int DIM_DEF  = 8;
    localparam int BITS_DEF = 8;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } coll_state_e;

endpackage

// File: rtl/row_collect_fifo.sv
// Serial-to-parallel row collector with a single hold register (double buffered).
// Element k of a row lands in Cout[DIM-1-k]; a full collector stalls until the hold register frees.
module row_collect_fifo
    import systolic_pkg::*;
#(
    parameter int DIM  = DIM_DEF,
    parameter int BITS = BITS_DEF,
    localparam int CW  = $clog2(DIM + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [BITS-1:0] Cin,
    output logic            ready,
    input  logic            rd,
    output logic [BITS-1:0] Cout [DIM-1:0],
    output logic            Cvalid,
    output logic [CW-1:0]   count
);

    localparam logic [CW-1:0] LAST = CW'(DIM - 1);
    localparam logic [CW-1:0] FULL = CW'(DIM);

    coll_state_e     state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BITS-1:0] coll_q [DIM-1:0];
    logic [BITS-1:0] coll_d [DIM-1:0];
    logic [BITS-1:0] cout_q [DIM-1:0];
    logic [BITS-1:0] cout_d [DIM-1:0];
    logic            cvalid_q, cvalid_d;
    logic            accept, xfer_ok;

    assign ready   = (state_q == FILL);
    assign accept  = en && ready;
    assign xfer_ok = !cvalid_q || rd;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        coll_d   = coll_q;
        cout_d   = cout_q;
        cvalid_d = cvalid_q;

        // A consumed row drops Cvalid unless a transfer below re-asserts it.
        if (rd && cvalid_q)
            cvalid_d = 1'b0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < DIM; i++)
                        if (i == DIM - 1 - int'(count_q))
                            coll_d[i] = Cin;
                    if (count_q == LAST) begin
                        if (xfer_ok) begin
                            cout_d   = coll_d;
                            cvalid_d = 1'b1;
                            count_d  = '0;
                        end else begin
                            count_d  = FULL;
                            state_d  = STALL;
                        end
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            STALL: begin
                if (xfer_ok) begin
                    cout_d   = coll_q;
                    cvalid_d = 1'b1;
                    count_d  = '0;
                    state_d  = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            count_q <= '0;
            for (int i = 0; i < DIM; i++)
                coll_q[i] <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            coll_q  <= coll_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cvalid_q <= 1'b0;
            for (int i = 0; i < DIM; i++)
                cout_q[i] <= '0;
        end else begin
            cvalid_q <= cvalid_d;
            cout_q   <= cout_d;
        end
    end

    assign Cout   = cout_q;
    assign Cvalid = cvalid_q;
    assign count  = count_q;

endmodule
